// File: rtl/sig_debounce_pkg.sv
// Shared types and helpers for the sig_debounce input-conditioning stage.
// The optional glitch counter is controlled by SIG_DEBOUNCE_GLITCH_CNT_EN.
package sig_debounce_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int GLITCH_W = 16;

    // Smallest width w (at least 1) such that 2**w >= n.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sig_debounce_sync_chain.sv
// Plain flop chain that brings an asynchronous input into the clk domain.
// It is shared by other asynchronous inputs, so it stays generic.
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RST_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; nothing sits between the stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_LEVEL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Synchronise a raw input and only pass a level change once it has stayed
// stable for DB_CYCLES consecutive cycles. Defining
// SIG_DEBOUNCE_GLITCH_CNT_EN adds a saturating count of rejected changes.
module sig_debounce
    import sig_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 1000,
    parameter logic RST_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sig_in,
    output logic                sig_out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int            CW       = cnt_width(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RST_LEVEL (RST_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .q     (sync_q)
    );

    // State, qualification counter and the registered clean level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= RST_LEVEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Decide whether a mismatch starts, continues, completes or aborts qualification.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (sync_q != out_q) begin
                    if (DB_CYCLES == 1) begin
                        out_d = sync_q;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                if (sync_q == out_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    out_d   = sync_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign sig_out = out_q;
    assign busy    = (state_q == COUNT);

`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_q;

    // Count every bounce back out of COUNT, holding at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else if ((state_q == COUNT) && (sync_q == out_q) && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = '0;
`endif

endmodule
